regu_sp_ramp: RTL and testbench
===============================

# regu_sp_ramp

- Slew-rate-limited set-point generator that drives the set-point word consumed by the regulation interlock monitor.
- Moves its output from the present value toward a loaded target in bounded steps at a programmable interval.
- Holds the regulation-check enable low while the ramp is in progress, so the monitor never evaluates an intermediate value.
- Sits between the host register block and the regulation interlock; it feeds that block's set-point and enable inputs and takes its interlock flag back.

## Interface
Parameters:
- none; all widths are fixed at 32 bits.

Ports:
- i_clk  in  1  system clock; one clock domain.
- i_rst  in  1  asynchronous, active-low reset.
- i_target  in  32  requested final set point, signed two's complement.
- i_step  in  32  step magnitude per update, unsigned.
- i_period  in  32  wait cycles between updates, unsigned.
- i_load  in  1  single-cycle pulse; latch i_target and start or retarget the ramp.
- i_abort  in  1  stop the ramp and hold the present output.
- i_intl  in  1  interlock trip, typically the regulation flag; forces the output to zero.
- i_clr  in  1  clears the latched interlock.
- o_set_point  out  32  present set point, signed, registered.
- o_busy  out  1  high in WAIT or STEP.
- o_done  out  1  one-cycle pulse when the target is reached.
- o_regu_en  out  1  enable for the regulation check.
- o_intl_latched  out  1  interlock latched; loads are blocked while high.
- o_state  out  2  current state, for debug.

## Operation
- States: IDLE=0, WAIT=1, STEP=2, DONE=3.
- Internal registers: tgt_buf (32b), wait_cnt (32b).
- Priority within any cycle: i_intl > i_abort > i_load > normal sequencing.

State behaviour:
- IDLE, i_load=1 and o_intl_latched=0:
  - tgt_buf <= i_target.
  - If i_target == o_set_point, go to DONE; otherwise go to WAIT.
- WAIT:
  - wait_cnt is 0 on entry and increments each cycle.
  - Go to STEP on the cycle where wait_cnt >= i_period.
- STEP:
  - diff = tgt_buf - o_set_point, computed in 33-bit signed.
  - If |diff| <= i_step (unsigned compare, 33-bit): o_set_point <= tgt_buf, go to DONE.
  - Otherwise o_set_point <= o_set_point + i_step if diff > 0, or - i_step if diff < 0; return to WAIT.
  - No overflow is possible, because the result always lies strictly between the old value and tgt_buf.
- DONE: o_done=1 for one cycle, then go to IDLE.

Retargeting:
- i_load in WAIT or STEP: tgt_buf <= i_target and wait_cnt <= 0.
- The ramp continues from the current o_set_point; no step is applied in that cycle.
- Next state is WAIT, or DONE if i_target equals o_set_point.
- i_load in DONE is treated as a load from IDLE.

Abort and interlock:
- i_abort in any state: go to IDLE, hold o_set_point, set tgt_buf <= o_set_point, no o_done.
- i_intl=1 in any state:
  - o_set_point <= 0, tgt_buf <= 0, state goes to IDLE.
  - o_intl_latched <= 1; no o_done pulse.
- o_intl_latched clears only on i_clr=1 with i_intl=0. If both are high, i_intl wins and the latch stays set.

Outputs:
- i_step = 0 means "jump": the first STEP writes tgt_buf directly.
- o_regu_en = (state==IDLE) && ~o_intl_latched && (o_set_point == tgt_buf).
- o_regu_en is decoded from registers only; there is no combinational path from inputs.

## Timing
- Reset values:
  - state=IDLE.
  - o_set_point=0, tgt_buf=0, wait_cnt=0.
  - o_busy=0, o_done=0, o_intl_latched=0.
  - o_regu_en=1, since 0 == 0.
- Load to first update:
  - i_load at edge N, WAIT from N+1.
  - STEP occupies cycle N+1+i_period+1.
  - The new o_set_point is visible the following cycle.
- Update interval: i_period+2 cycles per step.
- Step count: ceil(|target - start| / i_step) steps.
- Final step: o_done is high the cycle after it; o_regu_en rises the cycle after o_done.
- i_intl: output is 0 and o_regu_en is 0 one edge after assertion.
- Reset mid-ramp: all registers return to reset values immediately (asynchronous); no o_done.

## Test plan
- Basic ramp: reset, then load target=1000, step=300, period=2.
  - Set point goes 300, 600, 900, 1000, one update every 4 cycles.
  - o_done pulses once; o_regu_en is low throughout, then high.
- Negative target: load target=-500, step=200.
  - Set point goes -200, -400, -500; o_busy is high throughout.
- Jump and no-op loads:
  - step=0 with target=7: set point goes straight to 7 after period+2 cycles.
  - Reloading target=7 goes to DONE in 1 cycle, with o_done and no WAIT.
- Retarget mid-ramp:
  - From 600 heading to 1000, load target=0 during WAIT.
  - Ramp reverses to 300 then 0, with a single o_done.
- Interlock:
  - i_intl during ramp: set point is 0 the next cycle and o_intl_latched=1.
  - i_load is ignored while latched.
  - i_clr with i_intl=1 keeps the latch; i_clr with i_intl=0 clears it.
- Abort and reset:
  - i_abort at 600: output holds 600, no o_done, o_regu_en=1.
  - i_rst low mid-ramp: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/regu_sp_ramp.sv
// regu_sp_ramp: slew-rate-limited set-point generator.
//
// Moves o_set_point from its present value toward a loaded target in steps
// of at most i_step, one step every i_period+2 cycles. While the ramp runs,
// o_regu_en stays low, so the downstream regulation monitor never judges an
// intermediate value. An interlock trip forces the set point to zero and
// latches until it is cleared.
//
// Ports:
//   i_clk           system clock
//   i_rst           asynchronous reset, active low
//   i_target        requested final set point (signed)
//   i_step          step magnitude per update (unsigned, 0 = jump)
//   i_period        wait cycles between updates (unsigned)
//   i_load          pulse: latch i_target and start or retarget the ramp
//   i_abort         stop the ramp and hold the present output
//   i_intl          interlock trip: force output to zero and latch
//   i_clr           clear the interlock latch (ignored while i_intl is high)
//   o_set_point     present set point (signed, registered)
//   o_busy          high in WAIT or STEP
//   o_done          one-cycle pulse when the target is reached
//   o_regu_en       enable for the regulation check
//   o_intl_latched  interlock latched; loads are blocked while high
//   o_state         current FSM state (IDLE=0, WAIT=1, STEP=2, DONE=3)
//
// Control priority each cycle: i_intl > i_abort > i_load > sequencing.
module regu_sp_ramp (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_target,
  input  logic [31:0] i_step,
  input  logic [31:0] i_period,
  input  logic        i_load,
  input  logic        i_abort,
  input  logic        i_intl,
  input  logic        i_clr,
  output logic [31:0] o_set_point,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_regu_en,
  output logic        o_intl_latched,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] set_point_q, set_point_d;
  logic [31:0] tgt_buf_q, tgt_buf_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        intl_latched_q, intl_latched_d;

  // 33-bit difference so that extreme targets cannot wrap; bit 32 is the sign.
  logic [32:0] diff;
  logic [32:0] diff_mag;
  logic        step_final;

  always_comb begin
    diff       = {tgt_buf_q[31], tgt_buf_q} - {set_point_q[31], set_point_q};
    diff_mag   = diff[32] ? (33'd0 - diff) : diff;
    // A zero step means "jump": the first update lands on the target.
    step_final = (i_step == 32'd0) || (diff_mag <= {1'b0, i_step});
  end

  always_comb begin
    state_d        = state_q;
    set_point_d    = set_point_q;
    tgt_buf_d      = tgt_buf_q;
    wait_cnt_d     = wait_cnt_q;
    intl_latched_d = intl_latched_q;

    if (i_clr && !i_intl) begin
      intl_latched_d = 1'b0;
    end

    if (i_intl) begin
      state_d        = ST_IDLE;
      set_point_d    = 32'd0;
      tgt_buf_d      = 32'd0;
      wait_cnt_d     = 32'd0;
      intl_latched_d = 1'b1;
    end else if (i_abort) begin
      // Target collapses onto the held output so o_regu_en reasserts.
      state_d    = ST_IDLE;
      tgt_buf_d  = set_point_q;
      wait_cnt_d = 32'd0;
    end else if (i_load && !intl_latched_q) begin
      // Same path for a fresh load and a retarget: the ramp restarts its
      // interval from the current output and skips any step this cycle.
      tgt_buf_d  = i_target;
      wait_cnt_d = 32'd0;
      state_d    = (i_target == set_point_q) ? ST_DONE : ST_WAIT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_WAIT: begin
          if (wait_cnt_q >= i_period) begin
            state_d    = ST_STEP;
            wait_cnt_d = 32'd0;
          end else begin
            wait_cnt_d = wait_cnt_q + 32'd1;
          end
        end
        ST_STEP: begin
          if (step_final) begin
            set_point_d = tgt_buf_q;
            state_d     = ST_DONE;
          end else begin
            set_point_d = diff[32] ? (set_point_q - i_step) : (set_point_q + i_step);
            state_d     = ST_WAIT;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q        <= ST_IDLE;
      set_point_q    <= 32'd0;
      tgt_buf_q      <= 32'd0;
      wait_cnt_q     <= 32'd0;
      intl_latched_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      set_point_q    <= set_point_d;
      tgt_buf_q      <= tgt_buf_d;
      wait_cnt_q     <= wait_cnt_d;
      intl_latched_q <= intl_latched_d;
    end
  end

  // All outputs decode registers only; nothing passes straight from inputs.
  assign o_set_point    = set_point_q;
  assign o_busy         = (state_q == ST_WAIT) || (state_q == ST_STEP);
  assign o_done         = (state_q == ST_DONE);
  assign o_regu_en      = (state_q == ST_IDLE) && !intl_latched_q && (set_point_q == tgt_buf_q);
  assign o_intl_latched = intl_latched_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_regu_sp_ramp.sv
// Testbench for regu_sp_ramp.
// Drivers push expected set-point updates (value + edge index) and expected
// o_done edges into queues; a monitor sampling 1 ns after each rising edge
// pops and compares whenever the DUT output changes or o_done is high.
module tb_regu_sp_ramp;

  // ---------------- clock / reset ----------------
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_target, i_step, i_period;
  logic        i_load, i_abort, i_intl, i_clr;
  logic [31:0] o_set_point;
  logic        o_busy, o_done, o_regu_en, o_intl_latched;
  logic [1:0]  o_state;

  always #5 i_clk = ~i_clk;

  regu_sp_ramp dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_target       (i_target),
    .i_step         (i_step),
    .i_period       (i_period),
    .i_load         (i_load),
    .i_abort        (i_abort),
    .i_intl         (i_intl),
    .i_clr          (i_clr),
    .o_set_point    (o_set_point),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_regu_en      (o_regu_en),
    .o_intl_latched (o_intl_latched),
    .o_state        (o_state)
  );

  // ---------------- scoreboard state ----------------
  // exp_q entry: {ramp_flag, edge[30:0], value[31:0]}
  logic [63:0] exp_q[$];
  int          done_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          last_exp_sp = 0;
  bit          latched_model = 1'b0;
  bit          mon_en = 1'b0;
  logic [31:0] prev_sp = 32'd0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, $signed(act), $signed(exp));
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge i_clk) begin
    logic [63:0] ent;
    #1;
    if (mon_en) begin
      if (o_set_point !== prev_sp) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sp_unexpected at cycle %0d: got %0d want no change from %0d",
                   cyc, $signed(o_set_point), $signed(prev_sp));
        end else begin
          ent = exp_q.pop_front();
          last_exp_sp = int'($signed(ent[31:0]));
          if (int'(ent[62:32]) != cyc || ent[31:0] !== o_set_point) begin
            errors++;
            $display("FAIL sp_update at cycle %0d: got %0d want %0d at cycle %0d",
                     cyc, $signed(o_set_point), $signed(ent[31:0]), int'(ent[62:32]));
          end
        end
      end
      while (exp_q.size() != 0 && int'(exp_q[0][62:32]) <= cyc) begin
        ent = exp_q.pop_front();
        last_exp_sp = int'($signed(ent[31:0]));
        checks++;
        errors++;
        $display("FAIL sp_missing at cycle %0d: got %0d want %0d",
                 cyc, $signed(o_set_point), $signed(ent[31:0]));
      end
      while (done_q.size() != 0 && done_q[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL done_missing at cycle %0d: got no pulse want pulse at cycle %0d", cyc, done_q[0]);
        void'(done_q.pop_front());
      end
      if (o_done) begin
        checks++;
        if (done_q.size() != 0 && done_q[0] == cyc) begin
          void'(done_q.pop_front());
        end else begin
          errors++;
          $display("FAIL done_unexpected at cycle %0d: got pulse want none", cyc);
        end
      end
      // While a ramp update is still pending the block must be busy and
      // must keep the regulation check disabled.
      if (exp_q.size() != 0 && exp_q[0][63] && int'(exp_q[0][62:32]) > cyc) begin
        checks++;
        if (o_busy !== 1'b1 || o_regu_en !== 1'b0) begin
          errors++;
          $display("FAIL ramp_flags at cycle %0d: got busy=%0b regu_en=%0b want busy=1 regu_en=0",
                   cyc, o_busy, o_regu_en);
        end
      end
      prev_sp = o_set_point;
    end
  end

  // ---------------- driver tasks ----------------
  // Reference ramp: plain arithmetic over the slew rule, one update every
  // period+2 edges after the load edge.
  task automatic do_load(input int tgt, input int unsigned stp, input int unsigned per);
    longint v, d, s;
    int     n, e;
    @(negedge i_clk);
    i_target = tgt;
    i_step   = stp;
    i_period = per;
    i_load   = 1'b1;
    n = cyc + 1;
    if (!latched_model) begin
      exp_q.delete();
      done_q.delete();
      v = longint'(last_exp_sp);
      s = longint'(stp);
      e = n;
      while (v != longint'(tgt)) begin
        d = longint'(tgt) - v;
        e = e + int'(per) + 2;
        if (s == 0 || (d < 0 ? -d : d) <= s) v = longint'(tgt);
        else if (d > 0) v = v + s;
        else v = v - s;
        exp_q.push_back({1'b1, e[30:0], v[31:0]});
      end
      done_q.push_back(e);
    end
    @(negedge i_clk);
    i_load = 1'b0;
  endtask

  task automatic do_abort();
    @(negedge i_clk);
    i_abort = 1'b1;
    exp_q.delete();
    done_q.delete();
    @(negedge i_clk);
    i_abort = 1'b0;
    chk("abort_regu_en", o_regu_en, 1);
    chk("abort_busy", o_busy, 0);
    chk("abort_state", o_state, 0);
  endtask

  task automatic do_intl();
    int n;
    @(negedge i_clk);
    i_intl = 1'b1;
    exp_q.delete();
    done_q.delete();
    n = cyc + 1;
    if (last_exp_sp != 0) exp_q.push_back({1'b0, n[30:0], 32'd0});
    latched_model = 1'b1;
    @(negedge i_clk);
    i_intl = 1'b0;
    chk("intl_latched", o_intl_latched, 1);
    chk("intl_regu_en", o_regu_en, 0);
    chk("intl_busy", o_busy, 0);
  endtask

  task automatic do_clr(input bit with_intl);
    @(negedge i_clk);
    i_clr  = 1'b1;
    i_intl = with_intl;
    if (!with_intl) latched_model = 1'b0;
    @(negedge i_clk);
    i_clr  = 1'b0;
    i_intl = 1'b0;
    chk(with_intl ? "clr_blocked_latch" : "clr_latch", o_intl_latched, latched_model);
    if (!with_intl) chk("clr_regu_en", o_regu_en, 1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < max_cyc) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL idle_timeout at cycle %0d: got %0d pending want 0", cyc, exp_q.size() + done_q.size());
      exp_q.delete();
      done_q.delete();
    end
    @(negedge i_clk);
    if (!latched_model) begin
      chk("idle_regu_en", o_regu_en, 1);
      chk("idle_busy", o_busy, 0);
    end
  endtask

  task automatic wait_for_sp(input int v, input int max_cyc);
    int n;
    n = 0;
    while (last_exp_sp != v && n < max_cyc) begin
      @(negedge i_clk);
      n++;
    end
    chk("reach_sp", last_exp_sp, v);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_sp"}, o_set_point, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_regu_en"}, o_regu_en, 1);
    chk({tag, "_latched"}, o_intl_latched, 0);
    chk({tag, "_state"}, o_state, 0);
  endtask

  // Reset asserted mid-cycle, away from any clock edge.
  task automatic do_async_reset();
    @(negedge i_clk);
    mon_en = 1'b0;
    #2 i_rst = 1'b0;
    #1 check_reset_values("async_rst");
    @(negedge i_clk);
    exp_q.delete();
    done_q.delete();
    last_exp_sp   = 0;
    latched_model = 1'b0;
    prev_sp       = 32'd0;
    i_load = 1'b0; i_abort = 1'b0; i_intl = 1'b0; i_clr = 1'b0;
    i_rst  = 1'b1;
    mon_en = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5000000;
    $display("FAIL watchdog at cycle %0d: got no finish want finish", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t, op;
    i_rst = 1'b0;
    i_target = 32'd0; i_step = 32'd0; i_period = 32'd0;
    i_load = 1'b0; i_abort = 1'b0; i_intl = 1'b0; i_clr = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset_values("reset");
    i_rst  = 1'b1;
    mon_en = 1'b1;
    @(negedge i_clk);

    // Basic ramp: 300, 600, 900, 1000 every 4 cycles.
    do_load(1000, 300, 2);
    chk("load_state_wait", o_state, 1);
    chk("load_busy", o_busy, 1);
    wait_idle(200);

    // Jump back to zero with a zero step.
    do_load(0, 0, 0);
    wait_idle(50);

    // Negative target: -200, -400, -500.
    do_load(-500, 200, 1);
    wait_idle(200);

    // Jump to 7, then a no-op reload of 7 goes straight to DONE.
    do_load(7, 0, 3);
    wait_idle(50);
    do_load(7, 0, 3);
    chk("noop_state_done", o_state, 3);
    chk("noop_done", o_done, 1);
    wait_idle(20);

    // Retarget mid-ramp: from 600 heading to 1000, reverse to 0.
    do_async_reset();
    do_load(1000, 300, 2);
    wait_for_sp(600, 100);
    do_load(0, 300, 2);
    wait_idle(200);

    // Abort at 600: output holds, no done.
    do_load(1000, 300, 2);
    wait_for_sp(600, 100);
    do_abort();
    repeat (10) @(negedge i_clk);
    chk("abort_hold_regu_en", o_regu_en, 1);

    // Interlock during a ramp, blocked load, latch clearing.
    do_load(-2000, 100, 1);
    repeat (7) @(negedge i_clk);
    do_intl();
    do_load(500, 100, 1);
    repeat (10) @(negedge i_clk);
    chk("latched_load_busy", o_busy, 0);
    chk("latched_load_state", o_state, 0);
    do_clr(1'b1);
    do_clr(1'b0);

    // Reset in the middle of a ramp.
    do_load(5000, 100, 0);
    repeat (6) @(negedge i_clk);
    do_async_reset();
    repeat (3) @(negedge i_clk);

    // Randomized loads with occasional retarget, abort or interlock.
    for (int r = 0; r < 40; r++) begin
      op = int'($urandom_range(0, 9));
      t  = int'($urandom_range(0, 4000)) - 2000;
      do_load(t, $urandom_range(0, 12) * 50, $urandom_range(0, 4));
      if (op >= 5) begin
        repeat ($urandom_range(1, 25)) @(negedge i_clk);
        if (op < 7) begin
          t = int'($urandom_range(0, 4000)) - 2000;
          do_load(t, $urandom_range(0, 12) * 50, $urandom_range(0, 4));
        end else if (op < 9) begin
          do_abort();
        end else begin
          do_intl();
          do_clr(1'b0);
        end
      end
      wait_idle(5000);
    end

    repeat (5) @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
